// File: rtl/pixel_dispatcher.sv
// Walks a ROWS x COLS grid, issues one calculator task per pixel and streams
// the tagged results. Optional WAIT watchdog: PIXEL_DISPATCHER_TIMEOUT_EN.
module pixel_dispatcher #(
    parameter int WIDTH          = 20,
    parameter int FRACTIONAL     = 10,
    parameter int COLS           = 640,
    parameter int ROWS           = 480,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             job_start,
    input  logic [WIDTH-1:0] x_origin,
    input  logic [WIDTH-1:0] y_origin,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] c_real_in,
    input  logic [WIDTH-1:0] c_imag_in,
    output logic             calc_start,
    output logic [WIDTH-1:0] z_real_out,
    output logic [WIDTH-1:0] z_imag_out,
    output logic [WIDTH-1:0] c_real_out,
    output logic [WIDTH-1:0] c_imag_out,
    output logic [7:0]       iteration_out,
    input  logic             calc_done,
    input  logic [7:0]       pixel,
    output logic [7:0]       pix_data,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             pix_last,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             job_busy,
    output logic             job_done,
    output logic             timeout_flag
);

    if (FRACTIONAL >= WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pixel_dispatcher: FRACTIONAL must be < WIDTH and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [XW-1:0] COL_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] ROW_MAX = YW'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_lat;
    logic [WIDTH-1:0] step_lat;

    logic [XW-1:0] col_next;
    logic [YW-1:0] row_next;
    logic          col_wrap;

`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wd_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    assign iteration_out = '0;

    always_comb begin
        col_wrap = (pix_x == COL_MAX);
        col_next = pix_x + 1'b1;
        row_next = pix_y + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            x_lat      <= '0;
            step_lat   <= '0;
            calc_start <= 1'b0;
            z_real_out <= '0;
            z_imag_out <= '0;
            c_real_out <= '0;
            c_imag_out <= '0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_last   <= 1'b0;
            pix_valid  <= 1'b0;
            job_busy   <= 1'b0;
            job_done   <= 1'b0;
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            job_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_start) begin
                        x_lat      <= x_origin;
                        step_lat   <= step;
                        z_real_out <= x_origin;
                        z_imag_out <= y_origin;
                        c_real_out <= c_real_in;
                        c_imag_out <= c_imag_in;
                        pix_x      <= '0;
                        pix_y      <= '0;
                        pix_last   <= (COLS == 1) && (ROWS == 1);
                        calc_start <= 1'b1;
                        job_busy   <= 1'b1;
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (calc_done) begin
                        pix_data   <= pixel;
                        calc_start <= 1'b0;
                        pix_valid  <= 1'b1;
                        state      <= OUTPUT;
                    end
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        pix_data     <= 8'hFF;
                        timeout_flag <= 1'b1;
                        calc_start   <= 1'b0;
                        pix_valid    <= 1'b1;
                        state        <= OUTPUT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                OUTPUT: begin
                    // pix_valid is always high here, so ready alone completes the beat
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_last) begin
                            job_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            calc_start <= 1'b1;
                            state      <= ISSUE;
                            if (col_wrap) begin
                                pix_x      <= '0;
                                pix_y      <= row_next;
                                z_real_out <= x_lat;
                                z_imag_out <= z_imag_out - step_lat;
                                pix_last   <= (row_next == ROW_MAX) && (COL_MAX == '0);
                            end else begin
                                pix_x      <= col_next;
                                z_real_out <= z_real_out + step_lat;
                                pix_last   <= (pix_y == ROW_MAX) && (col_next == COL_MAX);
                            end
                        end
                    end
                end
                DONE: begin
                    job_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomised self-checking bench for pixel_dispatcher on a 4x2 grid; the
// calculator stand-in answers after a chosen number of busy cycles.
module tb_pixel_dispatcher;

    localparam int W    = 20;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int NPIX = COLS * ROWS;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          job_start;
    logic [W-1:0]  x_origin, y_origin, step, c_real_in, c_imag_in;
    logic          calc_start;
    logic [W-1:0]  z_real_out, z_imag_out, c_real_out, c_imag_out;
    logic [7:0]    iteration_out;
    logic          calc_done;
    logic [7:0]    pixel;
    logic [7:0]    pix_data;
    logic [1:0]    pix_x;
    logic [0:0]    pix_y;
    logic          pix_last, pix_valid, pix_ready;
    logic          job_busy, job_done, timeout_flag;

    int total = 0;
    int bad   = 0;

    int lat    = 1;
    int cs_cnt = 0;
    bit to_mode = 1'b0;
    logic [W-1:0] fx0, fy0, fst, fcr, fci;

    always #5 clk = ~clk;

    pixel_dispatcher #(
        .WIDTH(W), .FRACTIONAL(10), .COLS(COLS), .ROWS(ROWS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .n_rst(n_rst), .job_start(job_start),
        .x_origin(x_origin), .y_origin(y_origin), .step(step),
        .c_real_in(c_real_in), .c_imag_in(c_imag_in),
        .calc_start(calc_start), .z_real_out(z_real_out), .z_imag_out(z_imag_out),
        .c_real_out(c_real_out), .c_imag_out(c_imag_out), .iteration_out(iteration_out),
        .calc_done(calc_done), .pixel(pixel), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .job_busy(job_busy), .job_done(job_done), .timeout_flag(timeout_flag)
    );

    // Calculator stand-in: done once calc_start has been high for lat earlier cycles.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cs_cnt <= 0;
        else        cs_cnt <= calc_start ? cs_cnt + 1 : 0;
    end
    assign calc_done = calc_start && (cs_cnt >= lat);
    assign pixel     = z_real_out[7:0] ^ z_imag_out[11:4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_zr(input int k);
        logic [W-1:0] r;
        r = fx0;
        for (int i = 0; i < k % COLS; i++) r = r + fst;
        return r;
    endfunction

    function automatic logic [W-1:0] model_zi(input int k);
        logic [W-1:0] r;
        r = fy0;
        for (int i = 0; i < k / COLS; i++) r = r - fst;
        return r;
    endfunction

    function automatic logic [7:0] model_pix(input int k);
        logic [W-1:0] a, b;
        a = model_zr(k);
        b = model_zi(k);
        return to_mode ? 8'hFF : (a[7:0] ^ b[11:4]);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_cs"},    32'(calc_start), 0);
        check({tag, "_zr"},    32'(z_real_out), 0);
        check({tag, "_zi"},    32'(z_imag_out), 0);
        check({tag, "_cr"},    32'(c_real_out), 0);
        check({tag, "_ci"},    32'(c_imag_out), 0);
        check({tag, "_data"},  32'(pix_data), 0);
        check({tag, "_xy"},    32'({pix_x, pix_y}), 0);
        check({tag, "_flags"}, 32'({pix_last, pix_valid, job_busy, job_done, timeout_flag}), 0);
        check({tag, "_iter"},  32'(iteration_out), 0);
    endtask

    // lat_mode 0: random 1..4 per pixel, else fixed latency.
    // rdy_mode 0: random ready, 1: always ready, 2: 10-cycle stall on pixel 2.
    task automatic run_frame(input logic [W-1:0] x0, y0, st, cr, ci,
                             input int lat_mode, input int rdy_mode, input bit inject);
        int k, cyc, hi_run, low_run, last_rise, cur_lat, stall_cnt;
        bit prev_cs, prev_valid, prev_hs, prev_last, done_seen, injected, fast;
        k = 0; cyc = 0; hi_run = 0; low_run = 0; last_rise = 0; cur_lat = 1; stall_cnt = 0;
        prev_cs = 0; prev_valid = 0; prev_hs = 0; prev_last = 0; done_seen = 0; injected = 0;
        fast = (lat_mode == 1) && (rdy_mode == 1);
        fx0 = x0; fy0 = y0; fst = st; fcr = cr; fci = ci;
        x_origin = x0; y_origin = y0; step = st; c_real_in = cr; c_imag_in = ci;
        job_start = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("start_latency", 32'(calc_start), 1);
        check("busy_on", 32'(job_busy), 1);
        check("z_re_origin", 32'(z_real_out), 32'(x0));
        check("z_im_origin", 32'(z_imag_out), 32'(y0));
        while (!done_seen && cyc < 3000) begin
            job_start = 1'b0;
            check("done_pulse", 32'(job_done), 32'(prev_hs && prev_last));
            if (prev_hs && prev_last) begin
                done_seen = 1;
                check("valid_after_last", 32'(pix_valid), 0);
                check("busy_in_done", 32'(job_busy), 1);
                prev_hs = 0;
            end else begin
                if (prev_hs) check("issue_after_hs", 32'(calc_start), 1);
                if (calc_start && !prev_cs) begin
                    if (k > 0) begin
                        if (fast) begin
                            check("gap_low_one", 32'(low_run), 1);
                            check("pixel_period", 32'(cyc - last_rise), 3);
                        end else begin
                            check("gap_low_min", 32'(low_run >= 1), 1);
                        end
                    end
                    last_rise = cyc; low_run = 0; hi_run = 0;
                    cur_lat = (lat_mode == 0) ? $urandom_range(1, 4) : lat_mode;
                    if (to_mode) cur_lat = 100000;
                    lat = cur_lat;
                end
                if (calc_start) hi_run++; else low_run++;
                if (calc_start) begin
                    check("z_re", 32'(z_real_out), 32'(model_zr(k)));
                    check("z_im", 32'(z_imag_out), 32'(model_zi(k)));
                    check("c_pair", 32'(c_real_out ^ {c_imag_out[9:0], c_imag_out[19:10]}),
                          32'(fcr ^ {fci[9:0], fci[19:10]}));
                    check("valid_while_calc", 32'(pix_valid), 0);
                end
                if (pix_valid) begin
                    if (!prev_valid)
                        check("done_to_valid", 32'(hi_run), 32'((to_mode ? TO : cur_lat) + 1));
                    check("pix_data", 32'(pix_data), 32'(model_pix(k)));
                    check("pix_x", 32'(pix_x), 32'(k % COLS));
                    check("pix_y", 32'(pix_y), 32'(k / COLS));
                    check("pix_last", 32'(pix_last), 32'(k == NPIX - 1));
                    check("cs_low_in_output", 32'(calc_start), 0);
                    check("timeout_flag", 32'(timeout_flag), 32'(to_mode));
                    case (rdy_mode)
                        1: pix_ready = 1'b1;
                        2: begin
                            if (k == 2 && stall_cnt < 10) begin
                                pix_ready = 1'b0;
                                stall_cnt++;
                            end else begin
                                pix_ready = 1'b1;
                            end
                        end
                        default: pix_ready = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    pix_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (inject && !injected && k == 3 && calc_start) begin
                    job_start = 1'b1;
                    x_origin = ~x0; y_origin = ~y0; step = st + 20'd7;
                    injected = 1;
                end
                prev_hs   = pix_valid && pix_ready;
                prev_last = (k == NPIX - 1);
                if (prev_hs) k++;
            end
            prev_cs = calc_start;
            prev_valid = pix_valid;
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) check("frame_budget", 0, 1);
        check("beats", 32'(k), NPIX);
        check("busy_off", 32'(job_busy), 0);
        check("done_once", 32'(job_done), 0);
        check("z_hold_idle", 32'(z_real_out), 32'(model_zr(NPIX - 1)));
    endtask

    initial begin
        n_rst = 1'b0; job_start = 1'b0; pix_ready = 1'b0;
        x_origin = '0; y_origin = '0; step = '0; c_real_in = '0; c_imag_in = '0;
        @(negedge clk);
        check_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // -1.0 origin, +0.5 imag, 0.25 step, done two cycles after issue
        run_frame(20'hFFC00, 20'h00200, 20'h00100, 20'h00155, 20'hFFE80, 2, 1, 0);
        // immediate done, ready high: 3-cycle pixel period
        run_frame(20'h00040, 20'hFF000, 20'h00033, 20'h12345, 20'h0ABCD, 1, 1, 0);
        // 10-cycle backpressure on pixel 2
        run_frame(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 1, 2, 0);
        // mid-frame job_start must be ignored
        run_frame(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0, 1);
        // wrap-around at the top of the range
        run_frame(20'h7FF80, 20'h80010, 20'h00040, 20'h00001, 20'hFFFFF, 0, 0, 0);

        // reset while in WAIT
        x_origin = 20'h12345; y_origin = 20'h54321; step = 20'h00111;
        c_real_in = 20'h0F0F0; c_imag_in = 20'hF0F0F;
        lat = 50; job_start = 1'b1;
        @(negedge clk); job_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_calc", 32'(calc_start), 1);
        n_rst = 1'b0;
        #1;
        check_zero("midjob_reset");
        @(negedge clk);
        check("no_done_after_reset", 32'(job_done), 0);
        n_rst = 1'b1;
        @(negedge clk);
        run_frame(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0, 0);

        for (int f = 0; f < 3; f++)
            run_frame(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0, 0);

`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
        to_mode = 1'b1;
        run_frame(20'h00100, 20'h00200, 20'h00010, 20'h00003, 20'h00004, 1, 1, 0);
        to_mode = 1'b0;
        lat = 1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_dispatcher.md
# pixel_dispatcher

Drives the task side of `pixel_calculator`. It walks a ROWS×COLS grid and derives each pixel's starting z from a job origin and step. For each pixel it issues a calculation with the `calc_start` protocol, waits for `calc_done`, and captures the 8-bit `pixel` result. The result goes out on a valid/ready stream tagged with its coordinates. The block sits between the job-receive logic and the frame writer in Julia_Worker.

## Interface
- WIDTH, 20, fixed-point word width (two's complement)
- FRACTIONAL, 10, fractional bits (informational; arithmetic is plain add/sub)
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the macro)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- job_start  in  1  start pulse; sampled only in IDLE
- x_origin, y_origin  in  WIDTH  z of pixel (0,0)
- step  in  WIDTH  grid spacing
- c_real_in, c_imag_in  in  WIDTH  Julia constant
- calc_start  out  1  task active to calculator
- z_real_out, z_imag_out  out  WIDTH  starting z for current pixel
- c_real_out, c_imag_out  out  WIDTH  latched constant
- iteration_out  out  8  always 0
- calc_done  in  1  calculator finished (combinational from calculator)
- pixel  in  8  iteration count result
- pix_data  out  8  captured result
- pix_x  out  clog2(COLS)  column
- pix_y  out  clog2(ROWS)  row
- pix_last  out  1  final pixel of the frame
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready
- job_busy  out  1  high in any state except IDLE
- job_done  out  1  one-cycle pulse at frame end
- timeout_flag  out  1  sticky per job (macro only; tied 0 otherwise)

## Operation
- States: IDLE, ISSUE, WAIT, OUTPUT, DONE.
- **IDLE:**
  - On job_start, latch x_origin, y_origin, step and c_*.
  - Set col=0, row=0, zr=x_origin, zi=y_origin.
  - Go to ISSUE.
  - job_start in any other state is ignored.
- **ISSUE:**
  - calc_start=1 for 1 cycle, with z/c outputs stable.
  - calc_done is ignored in this state.
  - Go to WAIT.
- **WAIT:**
  - calc_start=1.
  - On calc_done=1, register pixel into pix_data and go to OUTPUT.
- **OUTPUT:**
  - calc_start=0, pix_valid=1.
  - pix_data, pix_x, pix_y and pix_last are held until the handshake completes.
  - Handshake is pix_valid & pix_ready in the same cycle. On handshake:
    - If last pixel, go to DONE.
    - Else if col==COLS-1: col=0, row+=1, zr=x_origin, zi-=step, go to ISSUE.
    - Else: col+=1, zr+=step, go to ISSUE.
- **DONE:** job_done=1 for 1 cycle, then IDLE.
- **Protocol rule:** calc_start is low for ≥1 cycle between consecutive tasks. The OUTPUT state guarantees this, and the low cycle clears the calculator's internal enable.
- **Arithmetic:** zr/zi are WIDTH-bit two's complement. Overflow wraps; there is no saturation.
- pix_last = (col==COLS-1 && row==ROWS-1).
- z_*_out, c_*_out hold their last values in IDLE.

## Timing
- **Reset:** state=IDLE; every output 0, including z_*/c_* registers, counters and timeout_flag.
- Reset mid-job abandons the frame. No job_done is issued.
- Job start latency: job_start at cycle N gives calc_start=1 at N+1.
- calc_done seen at cycle M in WAIT gives pix_valid=1 at M+1.
- Minimum per-pixel period is 3 cycles (ISSUE, WAIT with immediate done, OUTPUT with ready=1).
- Backpressure: pix_ready low stalls in OUTPUT indefinitely with calc_start=0. No data is lost.
- job_done is asserted the cycle after the final handshake. job_busy drops the cycle after that.

## Configuration
- Macro `PIXEL_DISPATCHER_TIMEOUT_EN`.
- **Defined:**
  - A watchdog counts cycles in WAIT.
  - If it reaches TIMEOUT_CYCLES without calc_done, pix_data is forced to 8'hFF, timeout_flag is set (sticky until the next job_start) and the state goes to OUTPUT.
  - The counter clears on entering WAIT.
- **Undefined:** no counter; WAIT waits forever; timeout_flag is tied 0.

## Test plan
- COLS=4, ROWS=2, x_origin=-1.0 (0xFFC00), y_origin=+0.5, step=0.25, calculator model returning done 2 cycles after calc_start → 8 stream beats with z_real_out sequence -1.0, -0.75, -0.5, -0.25, repeated. z_imag is +0.5 for row 0 and +0.25 for row 1. pix_last only on (3,1). job_done pulses once.
- Calculator returns done in the first WAIT cycle, pix_ready tied 1 → pixel period is exactly 3 cycles. calc_start is low for exactly 1 cycle between tasks.
- pix_ready held 0 for 10 cycles in OUTPUT → pix_data, pix_x and pix_y are stable and calc_start=0 throughout. The next ISSUE occurs the cycle after ready rises.
- job_start pulsed mid-frame with different origin → ignored. Frame completes with the original parameters.
- n_rst asserted in WAIT → all outputs 0 immediately. A later job_start runs a full frame from (0,0).
- With `PIXEL_DISPATCHER_TIMEOUT_EN`, TIMEOUT_CYCLES=8 and calculator never done → pix_data=8'hFF and timeout_flag=1, with the beat issued after 8 WAIT cycles. The frame continues.
